gpc_stim_gen: RTL
=================

GPC_STIM_GEN -- requirements
Module: gpc_stim_gen

Interface
REQ-001 SHALL have parameter NUM_VEC_W, default 16: width of num_vec and vec_idx.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a run.
REQ-005 SHALL have port mode  input  1  run mode: 0 = exhaustive sweep, 1 = LFSR run.
REQ-006 SHALL have port num_vec  input  NUM_VEC_W  vector count for the LFSR run.
REQ-007 SHALL have port seed  input  16  LFSR seed.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the vector.
REQ-009 SHALL have port out_valid  output  1  vector valid.
REQ-010 SHALL have port C0  output  2  weight-1 column bits.
REQ-011 SHALL have port C1  output  1  weight-2 column bit.
REQ-012 SHALL have port C2  output  3  weight-4 column bits.
REQ-013 SHALL have port golden  output  5  expected weighted sum of the current vector.
REQ-014 SHALL have port vec_idx  output  NUM_VEC_W  0-based index of the current vector.
REQ-015 SHALL have port busy  output  1  run in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at run end.

Function
REQ-017 SHALL implement the states IDLE, RUN and FIN; all outputs SHALL be registered.
REQ-018 SHALL act on start only in IDLE: sample mode, num_vec and seed, enter RUN next cycle, and ignore start in RUN or FIN.
REQ-019 SHALL, in RUN, hold out_valid=1; a transfer occurs on a cycle with out_valid and out_ready both 1.
REQ-020 SHALL hold C0, C1, C2, golden and vec_idx stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, after each transfer, present the next vector on the following cycle with no bubble, so one transfer per cycle is sustained when out_ready=1.
REQ-022 SHALL, in exhaustive mode, issue 64 vectors with vec_idx 0..63, where C0=vec_idx[1:0], C1=vec_idx[2] and C2=vec_idx[5:3].
REQ-023 SHALL, in LFSR mode, use a 16-bit Fibonacci LFSR: fb = l[15]^l[13]^l[12]^l[10], next = {l[14:0], fb}.
REQ-024 SHALL load the LFSR with seed, or with 16'hACE1 when seed = 0.
REQ-025 SHALL, in LFSR mode, map the current LFSR state to the vector as {C2,C1,C0} = l[5:0], with the first vector taken from the loaded value and the LFSR advancing once per transfer.
REQ-026 SHALL issue exactly num_vec vectors in LFSR mode.
REQ-027 SHALL, when num_vec = 0 in LFSR mode, go directly to FIN with no out_valid.
REQ-028 SHALL compute golden = popcount(C0) + 2*C1 + 4*popcount(C2), giving a range of 0..16 that is updated in the same cycle as the vector.
REQ-029 SHALL, on the transfer of the last vector, drop out_valid next cycle and enter FIN.
REQ-030 SHALL assert done for exactly one cycle in FIN, then return to IDLE.
REQ-031 SHALL drive busy=1 in RUN and FIN, and 0 in IDLE.
REQ-032 SHALL accept a start on the cycle immediately after FIN.
REQ-033 SHALL NOT wrap the vec_idx counter within a run; NUM_VEC_W >= 7 SHALL be required.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state=IDLE, out_valid=0, done=0, busy=0, C0=0, C1=0, C2=0, golden=0, vec_idx=0 and LFSR=16'hACE1.
REQ-035 SHALL abort any run in progress when reset is asserted mid-run, with no done pulse.
REQ-036 SHALL, after rst_n deasserts, require a new start to begin a run.

Verification
REQ-037 Exhaustive run: mode=0, out_ready=1, start pulse -> 64 consecutive transfers; idx 0 golden=0, idx 7 golden=4, idx 63 golden=16; done 1 cycle after the last transfer.
REQ-038 Backpressure: mode=0, out_ready toggling pseudo-randomly -> payload stable while stalled, all 64 vectors delivered in order, no loss or duplication.
REQ-039 LFSR run: mode=1, seed=16'h0001, num_vec=3 -> vectors l[5:0] = 6'h01, 6'h02, 6'h04 with golden 1, 1, 2; done after the 3rd transfer.
REQ-040 Edge inputs: seed=0 -> first vector 6'h21 (from 16'hACE1), golden=5; num_vec=0 -> done 1 cycle after entering RUN, out_valid never asserted.
REQ-041 Reset mid-run: rst_n low during exhaustive idx 20 -> outputs zero at once, no done; a fresh start restarts from idx 0.
REQ-042 Start while busy: start pulses during RUN are ignored, the run completes normally, and a start the cycle after done is accepted.

Source files
------------

// File: rtl/gpc_stim_gen.sv
// gpc_stim_gen: stimulus generator for a (2,1,3) generalized parallel counter.
// Emits column-bit vectors {C2,C1,C0} either as an exhaustive 64-vector sweep
// or as a run of num_vec vectors taken from a 16-bit Fibonacci LFSR, each paired
// with its expected weighted sum. Vectors are handed off over a valid/ready
// interface, and every output is registered.
module gpc_stim_gen #(
  parameter int NUM_VEC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NUM_VEC_W-1:0] num_vec,
  input  logic [15:0]          seed,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [1:0]           C0,
  output logic                 C1,
  output logic [2:0]           C2,
  output logic [4:0]           golden,
  output logic [NUM_VEC_W-1:0] vec_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  state_t               state_r;
  logic [15:0]          lfsr_r;
  logic                 mode_r;
  logic [NUM_VEC_W-1:0] last_idx_r;

  logic [15:0]          seed_load_s;
  logic [15:0]          lfsr_adv_s;
  logic [NUM_VEC_W-1:0] next_idx_s;
  logic [5:0]           first_vec_s;
  logic [5:0]           next_vec_s;

  // Weighted sum of a vector {C2,C1,C0}: popcount(C0) + 2*C1 + 4*popcount(C2).
  function automatic logic [4:0] golden_of(input logic [5:0] v);
    logic [1:0] pc0;
    logic [1:0] pc2;
    pc0 = {1'b0, v[0]} + {1'b0, v[1]};
    pc2 = {1'b0, v[3]} + {1'b0, v[4]} + {1'b0, v[5]};
    golden_of = {3'd0, pc0} + {3'd0, v[2], 1'b0} + {1'b0, pc2, 2'b00};
  endfunction

  // One step of the Fibonacci LFSR, taps 15,13,12,10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Next-vector candidates for the start cycle and for each transfer.
  always_comb begin
    seed_load_s = (seed == 16'd0) ? LFSR_DEFAULT : seed;
    lfsr_adv_s  = lfsr_next(lfsr_r);
    next_idx_s  = vec_idx + {{(NUM_VEC_W-1){1'b0}}, 1'b1};
    if (mode) begin
      first_vec_s = seed_load_s[5:0];
    end else begin
      first_vec_s = 6'd0;
    end
    if (mode_r) begin
      next_vec_s = lfsr_adv_s[5:0];
    end else begin
      next_vec_s = next_idx_s[5:0];
    end
  end

  // Run-control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      lfsr_r     <= LFSR_DEFAULT;
      mode_r     <= 1'b0;
      last_idx_r <= '0;
      out_valid  <= 1'b0;
      C0         <= 2'd0;
      C1         <= 1'b0;
      C2         <= 3'd0;
      golden     <= 5'd0;
      vec_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= RUN;
            busy    <= 1'b1;
            mode_r  <= mode;
            lfsr_r  <= seed_load_s;
            vec_idx <= '0;
            if (mode) begin
              last_idx_r <= num_vec - {{(NUM_VEC_W-1){1'b0}}, 1'b1};
            end else begin
              last_idx_r <= NUM_VEC_W'(63);
            end
            // An empty LFSR run spends one cycle in RUN without a vector.
            if (mode && (num_vec == '0)) begin
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
            end
            {C2, C1, C0} <= first_vec_s;
            golden       <= golden_of(first_vec_s);
          end else begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (!out_valid) begin
            state_r <= FIN;
            done    <= 1'b1;
          end else if (out_ready) begin
            lfsr_r <= lfsr_adv_s;
            if (vec_idx == last_idx_r) begin
              state_r   <= FIN;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              vec_idx      <= next_idx_s;
              {C2, C1, C0} <= next_vec_s;
              golden       <= golden_of(next_vec_s);
            end
          end else begin
            // Stalled: payload holds until the downstream accepts it.
            done <= 1'b0;
          end
        end
        FIN: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
